// File: rtl/roach_rst_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : roach_rst_pkg                                                |
// | Description : Shared types and helpers for the ROACH2 reset sequencer.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package roach_rst_pkg;

    typedef enum logic [2:0] {
        ST_POR_HOLD    = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_LOCK_SETTLE = 3'd2,
        ST_IDELAY_RST  = 3'd3,
        ST_IDELAY_WAIT = 3'd4,
        ST_RUN         = 3'd5,
        ST_FAULT       = 3'd6
    } seq_state_t;

    localparam int RELOCK_W = 8;

    // Wide enough to hold the largest timed-state reload value.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_2ff                                                     |
// | Description : Two-flop synchroniser bank for asynchronous level inputs.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/roach_rst_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : roach_rst_sequencer                                          |
// | Description : POR hold, lock qualification, IDELAYCTRL bring-up with retry |
// |               and user reset release, with relock counting and fault.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module roach_rst_sequencer
    import roach_rst_pkg::*;
#(
    parameter int                   NUM_LOCKS          = 2,
    parameter logic [NUM_LOCKS-1:0] LOCK_MASK          = '1,
    parameter int                   POR_CYCLES         = 1024,
    parameter int                   LOCK_STABLE_CYCLES = 4096,
    parameter int                   IDELAY_RST_CYCLES  = 16,
    parameter int                   IDELAY_TIMEOUT     = 1024,
    parameter int                   MAX_RETRIES        = 3
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [NUM_LOCKS-1:0] clk_lock,
    input  logic                 idelay_rdy,
    input  logic                 soft_restart,
    output logic                 op_power_on_rst,
    output logic                 idelay_rst,
    output logic                 user_rst,
    output logic                 ready,
    output logic                 fault,
    output logic [RELOCK_W-1:0]  relock_count,
    output logic [2:0]           seq_state
);

    localparam int c_cnt_w   = cnt_width(POR_CYCLES, LOCK_STABLE_CYCLES,
                                         IDELAY_RST_CYCLES, IDELAY_TIMEOUT);
    localparam int c_retry_w = $clog2(MAX_RETRIES + 1);

    localparam logic [c_cnt_w-1:0]   c_por_load    = c_cnt_w'(POR_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]   c_settle_load = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]   c_irst_load   = c_cnt_w'(IDELAY_RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]   c_iwait_load  = c_cnt_w'(IDELAY_TIMEOUT - 1);
    localparam logic [c_retry_w-1:0] c_retry_max   = c_retry_w'(MAX_RETRIES);

    logic [NUM_LOCKS-1:0] w_lock_s;
    logic                 w_rdy_s;
    logic                 w_lock_ok;

    sync_2ff #(.WIDTH(NUM_LOCKS)) u_sync_lock (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .i_d   (clk_lock),
        .o_q   (w_lock_s)
    );

    sync_2ff #(.WIDTH(1)) u_sync_rdy (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .i_d   (idelay_rdy),
        .o_q   (w_rdy_s)
    );

    // Unmasked lock bits are forced high so they never gate the AND.
    assign w_lock_ok = &(w_lock_s | ~LOCK_MASK);

    seq_state_t            r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_retry_w-1:0]  r_retry;
    logic [RELOCK_W-1:0]   r_relock;
    logic                  r_por;
    logic                  r_idelay_rst;
    logic                  r_user_rst;
    logic                  r_ready;
    logic                  r_fault;

    seq_state_t            w_state_nxt;
    logic [c_cnt_w-1:0]    w_cnt_nxt;
    logic [c_retry_w-1:0]  w_retry_nxt;
    logic [c_retry_w-1:0]  w_retry_inc;
    logic [RELOCK_W-1:0]   w_relock_nxt;
    logic                  w_entry;
    logic                  w_cnt_zero;

    function automatic logic [c_cnt_w-1:0] f_load(input seq_state_t s);
        case (s)
            ST_POR_HOLD:    f_load = c_por_load;
            ST_LOCK_SETTLE: f_load = c_settle_load;
            ST_IDELAY_RST:  f_load = c_irst_load;
            ST_IDELAY_WAIT: f_load = c_iwait_load;
            default:        f_load = '0;
        endcase
    endfunction

    always_comb begin
        w_state_nxt  = r_state;
        w_retry_nxt  = r_retry;
        w_relock_nxt = r_relock;
        w_entry      = 1'b0;
        w_cnt_zero   = (r_cnt == '0);
        w_retry_inc  = r_retry + 1'b1;

        if (soft_restart) begin
            w_state_nxt = ST_POR_HOLD;
            w_entry     = 1'b1;
        end else begin
            case (r_state)
                ST_POR_HOLD: begin
                    if (w_cnt_zero) w_state_nxt = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (w_lock_ok) w_state_nxt = ST_LOCK_SETTLE;
                end
                ST_LOCK_SETTLE: begin
                    if (!w_lock_ok)      w_state_nxt = ST_WAIT_LOCK;
                    else if (w_cnt_zero) w_state_nxt = ST_IDELAY_RST;
                end
                ST_IDELAY_RST: begin
                    if (!w_lock_ok)      w_state_nxt = ST_WAIT_LOCK;
                    else if (w_cnt_zero) w_state_nxt = ST_IDELAY_WAIT;
                end
                ST_IDELAY_WAIT: begin
                    if (!w_lock_ok) begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end else if (w_rdy_s) begin
                        w_state_nxt = ST_RUN;
                    end else if (w_cnt_zero) begin
                        w_retry_nxt = w_retry_inc;
                        w_state_nxt = (w_retry_inc == c_retry_max) ? ST_FAULT : ST_IDELAY_RST;
                    end
                end
                ST_RUN: begin
                    if (!w_lock_ok) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        if (r_relock != {RELOCK_W{1'b1}}) w_relock_nxt = r_relock + 1'b1;
                    end
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                default: begin
                    w_state_nxt = ST_POR_HOLD;
                end
            endcase
        end

        if (w_state_nxt != r_state) w_entry = 1'b1;

        if (soft_restart ||
            (w_entry && (w_state_nxt == ST_WAIT_LOCK || w_state_nxt == ST_RUN)))
            w_retry_nxt = '0;

        if (w_entry)         w_cnt_nxt = f_load(w_state_nxt);
        else if (w_cnt_zero) w_cnt_nxt = '0;
        else                 w_cnt_nxt = r_cnt - 1'b1;
    end

    // Outputs decode the next state so they move on the entering edge.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state      <= ST_POR_HOLD;
            r_cnt        <= c_por_load;
            r_retry      <= '0;
            r_relock     <= '0;
            r_por        <= 1'b1;
            r_idelay_rst <= 1'b0;
            r_user_rst   <= 1'b1;
            r_ready      <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_retry      <= w_retry_nxt;
            r_relock     <= w_relock_nxt;
            r_por        <= (w_state_nxt == ST_POR_HOLD);
            r_idelay_rst <= (w_state_nxt == ST_IDELAY_RST);
            r_user_rst   <= (w_state_nxt != ST_RUN);
            r_ready      <= (w_state_nxt == ST_RUN);
            r_fault      <= (w_state_nxt == ST_FAULT);
        end
    end

    assign op_power_on_rst = r_por;
    assign idelay_rst      = r_idelay_rst;
    assign user_rst        = r_user_rst;
    assign ready           = r_ready;
    assign fault           = r_fault;
    assign relock_count    = r_relock;
    assign seq_state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_roach_rst_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_roach_rst_sequencer                                       |
// | Description : Directed table-driven bench for roach_rst_sequencer.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_roach_rst_sequencer;

    localparam logic [4:0] c_o_por  = 5'b10100; // {por, idr, user_rst, ready, fault}
    localparam logic [4:0] c_o_wait = 5'b00100;
    localparam logic [4:0] c_o_idr  = 5'b01100;
    localparam logic [4:0] c_o_run  = 5'b00010;
    localparam logic [4:0] c_o_flt  = 5'b00101;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [1:0] clk_lock;
    logic       idelay_rdy;
    logic       soft_restart;
    logic       op_power_on_rst, idelay_rst, user_rst, ready, fault;
    logic [7:0] relock_count;
    logic [2:0] seq_state;

    logic       m_por, m_idr, m_urst, m_ready, m_fault;
    logic [7:0] m_relock;
    logic [2:0] m_state;

    int n_cmp = 0;
    int n_err = 0;
    int g_edge = 0;

    always #5 sys_clk = ~sys_clk;

    roach_rst_sequencer #(
        .NUM_LOCKS(2), .LOCK_MASK(2'b11), .POR_CYCLES(16), .LOCK_STABLE_CYCLES(32),
        .IDELAY_RST_CYCLES(8), .IDELAY_TIMEOUT(64), .MAX_RETRIES(2)
    ) u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_lock(clk_lock),
        .idelay_rdy(idelay_rdy), .soft_restart(soft_restart),
        .op_power_on_rst(op_power_on_rst), .idelay_rst(idelay_rst),
        .user_rst(user_rst), .ready(ready), .fault(fault),
        .relock_count(relock_count), .seq_state(seq_state)
    );

    // Second instance: only lock[0] participates, lock[1] tied low.
    roach_rst_sequencer #(
        .NUM_LOCKS(2), .LOCK_MASK(2'b01), .POR_CYCLES(16), .LOCK_STABLE_CYCLES(32),
        .IDELAY_RST_CYCLES(8), .IDELAY_TIMEOUT(64), .MAX_RETRIES(2)
    ) u_dut_m (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_lock({1'b0, clk_lock[0]}),
        .idelay_rdy(idelay_rdy), .soft_restart(soft_restart),
        .op_power_on_rst(m_por), .idelay_rst(m_idr),
        .user_rst(m_urst), .ready(m_ready), .fault(m_fault),
        .relock_count(m_relock), .seq_state(m_state)
    );

    typedef struct {
        int         at_edge;
        logic [1:0] lock_in;
        logic       rdy_in;
        logic [2:0] st;
        logic [4:0] outs;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int e, input logic [1:0] l, input logic r,
                                input logic [2:0] s, input logic [4:0] o);
        vec_t v;
        v.at_edge = e; v.lock_in = l; v.rdy_in = r; v.st = s; v.outs = o;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
            g_edge++;
        end
    endtask

    task automatic goto_edge(input int e);
        if (g_edge < e) tick(e - g_edge);
    endtask

    function automatic logic [4:0] outs_now();
        return {op_power_on_rst, idelay_rst, user_rst, ready, fault};
    endfunction

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            goto_edge(tbl[i].at_edge);
            chk($sformatf("%s@%0d.state", tag, tbl[i].at_edge), 32'(seq_state), 32'(tbl[i].st));
            chk($sformatf("%s@%0d.outs", tag, tbl[i].at_edge), 32'(outs_now()), 32'(tbl[i].outs));
            clk_lock   = tbl[i].lock_in;
            idelay_rdy = tbl[i].rdy_in;
        end
    endtask

    task automatic wait_ready(input int budget, input string nm);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        chk(nm, 32'(ready), 32'd1);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        tick(3);
        sys_rst_n = 1'b1;
        g_edge = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    initial begin
        sys_rst_n    = 1'b0;
        clk_lock     = 2'b11;
        idelay_rdy   = 1'b0;
        soft_restart = 1'b0;

        // Nominal bring-up, idelay_rdy first sampled 10 edges after idelay_rst falls.
        do_reset();
        tbl.delete();
        tbl.push_back(mk( 0, 2'b11, 1'b0, 3'd0, c_o_por));
        tbl.push_back(mk(15, 2'b11, 1'b0, 3'd0, c_o_por));
        tbl.push_back(mk(16, 2'b11, 1'b0, 3'd1, c_o_wait));
        tbl.push_back(mk(17, 2'b11, 1'b0, 3'd2, c_o_wait));
        tbl.push_back(mk(48, 2'b11, 1'b0, 3'd2, c_o_wait));
        tbl.push_back(mk(49, 2'b11, 1'b0, 3'd3, c_o_idr));
        tbl.push_back(mk(56, 2'b11, 1'b0, 3'd3, c_o_idr));
        tbl.push_back(mk(57, 2'b11, 1'b0, 3'd4, c_o_wait));
        tbl.push_back(mk(66, 2'b11, 1'b1, 3'd4, c_o_wait));
        tbl.push_back(mk(68, 2'b11, 1'b1, 3'd4, c_o_wait));
        tbl.push_back(mk(69, 2'b11, 1'b1, 3'd5, c_o_run));
        run_table("nominal");
        chk("nominal.relock", 32'(relock_count), 32'd0);
        chk("mask.state", 32'(m_state), 32'd5);
        chk("mask.ready", 32'(m_ready), 32'd1);

        // Lock loss in RUN: user_rst returns three edges after lock[0] falls.
        clk_lock = 2'b10;
        tick(2);
        chk("lossrun.still_ready", 32'(ready), 32'd1);
        tick(1);
        chk("lossrun.user_rst", 32'(user_rst), 32'd1);
        chk("lossrun.state", 32'(seq_state), 32'd1);
        chk("lossrun.relock1", 32'(relock_count), 32'd1);
        clk_lock = 2'b11;
        wait_ready(100, "lossrun.rerun");
        for (int i = 1; i < 300; i++) begin
            clk_lock = 2'b10;
            tick(3);
            clk_lock = 2'b11;
            wait_ready(100, $sformatf("lossrun.rerun%0d", i));
        end
        chk("lossrun.relock_sat", 32'(relock_count), 32'd255);

        // Soft restart from RUN with idelay_rdy stuck low: two pulses, then FAULT.
        idelay_rdy   = 1'b0;
        soft_restart = 1'b1;
        g_edge       = 0;
        tick(1);
        soft_restart = 1'b0;
        chk("timeout.relock_kept", 32'(relock_count), 32'd255);
        tbl.delete();
        tbl.push_back(mk(  1, 2'b11, 1'b0, 3'd0, c_o_por));
        tbl.push_back(mk( 16, 2'b11, 1'b0, 3'd0, c_o_por));
        tbl.push_back(mk( 17, 2'b11, 1'b0, 3'd1, c_o_wait));
        tbl.push_back(mk( 49, 2'b11, 1'b0, 3'd2, c_o_wait));
        tbl.push_back(mk( 50, 2'b11, 1'b0, 3'd3, c_o_idr));
        tbl.push_back(mk( 57, 2'b11, 1'b0, 3'd3, c_o_idr));
        tbl.push_back(mk( 58, 2'b11, 1'b0, 3'd4, c_o_wait));
        tbl.push_back(mk(121, 2'b11, 1'b0, 3'd4, c_o_wait));
        tbl.push_back(mk(122, 2'b11, 1'b0, 3'd3, c_o_idr));
        tbl.push_back(mk(129, 2'b11, 1'b0, 3'd3, c_o_idr));
        tbl.push_back(mk(130, 2'b11, 1'b0, 3'd4, c_o_wait));
        tbl.push_back(mk(193, 2'b11, 1'b0, 3'd4, c_o_wait));
        tbl.push_back(mk(194, 2'b11, 1'b0, 3'd6, c_o_flt));
        tbl.push_back(mk(230, 2'b11, 1'b0, 3'd6, c_o_flt));
        run_table("timeout");

        // Soft restart out of FAULT.
        soft_restart = 1'b1;
        g_edge       = 0;
        tick(1);
        soft_restart = 1'b0;
        chk("fault_exit.state", 32'(seq_state), 32'd0);
        chk("fault_exit.outs", 32'(outs_now()), 32'(c_o_por));

        // Reset asserted during IDELAY_WAIT.
        goto_edge(60);
        chk("midrst.pre_state", 32'(seq_state), 32'd4);
        sys_rst_n = 1'b0;
        tick(1);
        chk("midrst.state", 32'(seq_state), 32'd0);
        chk("midrst.outs", 32'(outs_now()), 32'(c_o_por));
        chk("midrst.relock", 32'(relock_count), 32'd0);

        // One-cycle glitch on lock[1] at settle cycle 20 restarts the settle window.
        do_reset();
        tbl.delete();
        tbl.push_back(mk( 0, 2'b11, 1'b0, 3'd0, c_o_por));
        tbl.push_back(mk(17, 2'b11, 1'b0, 3'd2, c_o_wait));
        tbl.push_back(mk(36, 2'b01, 1'b0, 3'd2, c_o_wait));
        tbl.push_back(mk(37, 2'b11, 1'b0, 3'd2, c_o_wait));
        tbl.push_back(mk(38, 2'b11, 1'b0, 3'd2, c_o_wait));
        tbl.push_back(mk(39, 2'b11, 1'b0, 3'd1, c_o_wait));
        tbl.push_back(mk(40, 2'b11, 1'b0, 3'd2, c_o_wait));
        tbl.push_back(mk(71, 2'b11, 1'b0, 3'd2, c_o_wait));
        tbl.push_back(mk(72, 2'b11, 1'b0, 3'd3, c_o_idr));
        run_table("glitch");
        chk("glitch.relock", 32'(relock_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
